// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the DMA start register copies LEN bytes from {base, idx}
// into PPU OAM, one byte per M-cycle tick, after a one-tick startup delay.
module oam_dma #(
  parameter logic [15:0] REG_ADDR = 16'hFF46,
  parameter int          LEN      = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        reg_wr_en,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        src_rd_req,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] base_q, base_d;

  logic       start;
  logic [7:0] eff_base;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    start    = reg_wr_en && (reg_addr == REG_ADDR);
    eff_base = (base_q >= 8'hE0) ? (base_q - 8'h20) : base_q;

    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;

    unique case (state_q)
      IDLE:  state_d = IDLE;
      DELAY: if (tick) state_d = READ;
      READ:  if (tick) state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start write wins in every state; a byte already in WRITE still lands this clk.
    if (start) begin
      base_d  = reg_wdata;
      idx_d   = 8'd0;
      state_d = DELAY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      base_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  // Bus strobes decode from state so the read lands on the tick and the write one clk later,
  // matching the one-clk source latency; a concurrent restart drops the pending read.
  always_comb begin
    src_rd_req = (state_q == READ) && tick && !start;
    src_addr   = src_rd_req ? {eff_base, idx_q} : 16'h0000;
    oam_we     = (state_q == WRITE);
    oam_addr   = oam_we ? idx_q : 8'h00;
    oam_wdata  = oam_we ? src_rdata : 8'h00;
    dma_active = (state_q != IDLE);
    reg_rdata  = base_q;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a scoreboard of expected source reads and OAM writes is
// filled when each transfer is started and drained by a monitor on the falling edge.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        reg_wr_en;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        src_rd_req;
  logic [15:0] src_addr;
  logic [7:0]  src_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_rd_q[$];
  logic [15:0] exp_wr_q[$];

  bit tick_en      = 1'b0;
  int tick_cnt     = 0;
  int ticks_seen   = 0;
  int rd_count     = 0;
  int last_rd_tick = 0;

  oam_dma #(.REG_ADDR(16'hFF46), .LEN(160)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .src_rd_req (src_rd_req),
    .src_addr   (src_addr),
    .src_rdata  (src_rdata),
    .oam_we     (oam_we),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return (a[7:0] ^ 8'hA5) + a[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_xfer(input logic [7:0] hi, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      logic [15:0] a;
      a = {hi, 8'(i)};
      exp_rd_q.push_back(a);
      exp_wr_q.push_back({8'(i), src_byte(a)});
    end
  endtask

  // Call at posedge+1: drives the write for this clk and releases it one clk later.
  task automatic drive_write(input logic [15:0] addr, input logic [7:0] data);
    reg_wr_en = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    @(posedge clk);
    #1;
    reg_wr_en = 1'b0;
    reg_addr  = 16'h0000;
    reg_wdata = 8'h00;
  endtask

  task automatic wait_wr(input string tag, input logic [7:0] target, input int budget);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      found = oam_we && (oam_addr == target);
    end
    check({tag, "_wr_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_first_read(input string tag, input int t0, input int r0);
    int n;
    n = 0;
    while (rd_count == r0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_first_rd_seen"}, 32'(rd_count != r0), 32'd1);
    check({tag, "_first_rd_tick"}, 32'(last_rd_tick - t0), 32'd2);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || dma_active) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_active_end"}, 32'(dma_active), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dma_active"}, 32'(dma_active), 32'd0);
    check({tag, "_src_rd_req"}, 32'(src_rd_req), 32'd0);
    check({tag, "_oam_we"},     32'(oam_we),     32'd0);
    check({tag, "_oam_addr"},   32'(oam_addr),   32'd0);
    check({tag, "_oam_wdata"},  32'(oam_wdata),  32'd0);
    check({tag, "_src_addr"},   32'(src_addr),   32'd0);
    check({tag, "_reg_rdata"},  32'(reg_rdata),  32'd0);
  endtask

  // M-cycle tick: one clk high every fourth clk while enabled.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_cnt++;
        tick = (tick_cnt % 4 == 0);
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Source memory: data for a request appears for the whole following clk.
  initial begin
    logic        req;
    logic [15:0] addr;
    src_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      req  = src_rd_req;
      addr = src_addr;
      @(posedge clk);
      #1;
      src_rdata = req ? src_byte(addr) : 8'hEE;
    end
  end

  // Monitor / scoreboard consumer.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (tick) ticks_seen++;
      if (src_rd_req || oam_we)
        check("rd_we_exclusive", 32'(src_rd_req & oam_we), 32'd0);
      if (src_rd_req) begin
        rd_count++;
        last_rd_tick = ticks_seen;
        check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0) begin
          e = exp_rd_q.pop_front();
          check("src_addr", 32'(src_addr), 32'(e));
        end
      end
      if (oam_we) begin
        check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          check("oam_addr",  32'(oam_addr),  32'(e[15:8]));
          check("oam_wdata", 32'(oam_wdata), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r0;
    int rd_viol;
    int act_viol;

    reset     = 1'b0;
    reg_wr_en = 1'b0;
    reg_addr  = 16'h0000;
    reg_wdata = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #2 reset = 1'b1;
    @(negedge clk);
    tick_en = 1'b1;

    // Write to a neighbouring address, with ticks running in IDLE.
    @(posedge clk);
    #1;
    drive_write(16'hFF47, 8'hC0);
    repeat (12) @(posedge clk);
    #2;
    check("nomatch_active", 32'(dma_active), 32'd0);
    check("nomatch_rdata",  32'(reg_rdata),  32'd0);

    // Basic transfer from C100.
    @(posedge clk);
    #1;
    drive_write(16'hFF46, 8'hC1);
    t0 = ticks_seen;
    r0 = rd_count;
    push_xfer(8'hC1, 0, 160);
    check("basic_rdata",  32'(reg_rdata),  32'hC1);
    check("basic_active", 32'(dma_active), 32'd1);
    wait_first_read("basic", t0, r0);
    wait_done("basic", 2000);

    // Echo-RAM fold: E2 reads from C200.
    @(posedge clk);
    #1;
    drive_write(16'hFF46, 8'hE2);
    t0 = ticks_seen;
    r0 = rd_count;
    push_xfer(8'hC2, 0, 160);
    check("echo_rdata", 32'(reg_rdata), 32'hE2);
    wait_first_read("echo", t0, r0);
    wait_done("echo", 2000);

    // Restart landing in the WRITE clk of byte 9.
    @(posedge clk);
    #1;
    drive_write(16'hFF46, 8'hC0);
    push_xfer(8'hC0, 0, 10);
    wait_wr("restart", 8'd9, 200);
    drive_write(16'hFF46, 8'hD0);
    t0 = ticks_seen;
    r0 = rd_count;
    push_xfer(8'hD0, 0, 160);
    check("restart_rdata", 32'(reg_rdata), 32'hD0);
    wait_first_read("restart", t0, r0);
    wait_done("restart", 2000);

    // Tick stalled for 20 clks while in READ.
    @(posedge clk);
    #1;
    drive_write(16'hFF46, 8'hC4);
    push_xfer(8'hC4, 0, 160);
    wait_wr("stall", 8'd20, 400);
    @(negedge clk);
    tick_en  = 1'b0;
    rd_viol  = 0;
    act_viol = 0;
    repeat (20) begin
      @(posedge clk);
      #2;
      if (src_rd_req) rd_viol++;
      if (!dma_active) act_viol++;
    end
    check("stall_no_rd",   32'(rd_viol),  32'd0);
    check("stall_active",  32'(act_viol), 32'd0);
    @(negedge clk);
    tick_en = 1'b1;
    wait_done("stall", 2000);

    // Reset in the READ phase of byte 50.
    @(posedge clk);
    #1;
    drive_write(16'hFF46, 8'hC3);
    push_xfer(8'hC3, 0, 50);
    wait_wr("rstmid", 8'd49, 600);
    @(posedge clk);
    #2;
    check("rstmid_active_before", 32'(dma_active), 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("rstmid");
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    check("rstmid_active_after", 32'(dma_active), 32'd0);
    check("rstmid_rdata_after",  32'(reg_rdata),  32'd0);
    check("rstmid_rd_left",      32'(exp_rd_q.size()), 32'd0);
    check("rstmid_wr_left",      32'(exp_wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter: REG_ADDR, default 16'hFF46, I/O address of the DMA start register.
REQ-002 Parameter: LEN, default 160, number of bytes per transfer.
REQ-003 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 Port: tick  in  1  M-cycle enable; one-clk pulse, one byte transferred per tick.
REQ-006 Port: reg_wr_en  in  1  CPU register write strobe.
REQ-007 Port: reg_addr  in  16  CPU register address.
REQ-008 Port: reg_wdata  in  8  CPU write data.
REQ-009 Port: reg_rdata  out  8  last value written to REG_ADDR.
REQ-010 Port: src_rd_req  out  1  one-clk source read request.
REQ-011 Port: src_addr  out  16  source read address.
REQ-012 Port: src_rdata  in  8  source data, valid exactly one clk after src_rd_req.
REQ-013 Port: oam_we  out  1  one-clk OAM write strobe into the PPU OAM.
REQ-014 Port: oam_addr  out  8  OAM byte index, 0..LEN-1.
REQ-015 Port: oam_wdata  out  8  OAM write data.
REQ-016 Port: dma_active  out  1  transfer in progress; PPU/CPU arbitration uses it.

Function
REQ-017 The block SHALL implement states IDLE, DELAY, READ and WRITE, plus an 8-bit byte index idx and an 8-bit base register.
REQ-018 The block SHALL treat reg_wr_en high with reg_addr==REG_ADDR, in any state, as a start: base<=reg_wdata, idx<=0, state<=DELAY on that clk.
REQ-019 DELAY: on the first tick, the block SHALL go to READ with no bus activity (one M-cycle startup delay).
REQ-020 READ: on a tick, the block SHALL assert src_rd_req for one clk with src_addr={eff_base, idx} and SHALL go to WRITE; with no tick it SHALL hold.
REQ-021 eff_base SHALL equal base-8'h20 when base>=8'hE0, else base (echo-RAM fold).
REQ-022 WRITE (one clk, no tick needed): the block SHALL assert oam_we with oam_addr=idx and oam_wdata=src_rdata.
REQ-023 After WRITE, if idx==LEN-1 the block SHALL go to IDLE; otherwise it SHALL increment idx and go to READ.
REQ-024 The first src_rd_req SHALL occur on the second tick after the start write.
REQ-025 The last oam_we SHALL occur one clk after the LEN-th READ tick.
REQ-026 dma_active SHALL be 1 in DELAY, READ and WRITE, and 0 in IDLE.
REQ-027 Restart during WRITE: the pending byte SHALL still be written that clk, then the new transfer SHALL begin in DELAY with idx=0.
REQ-028 Restart during DELAY or READ: the pending read SHALL be abandoned; no oam_we for the old base.
REQ-029 oam_addr SHALL never exceed LEN-1.
REQ-030 Writes to any other reg_addr SHALL be ignored.
REQ-031 A tick arriving in IDLE SHALL have no effect.
REQ-032 src_rd_req and oam_we SHALL never be high in the same clk.
REQ-033 reg_rdata SHALL be combinationally equal to base.

Reset
REQ-034 On reset low, the block SHALL set: state=IDLE, idx=0, base=8'h00, src_rd_req=0, oam_we=0, dma_active=0.
REQ-035 On reset low, oam_addr, oam_wdata and src_addr SHALL be 0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no further oam_we, and the block SHALL remain IDLE after release until the next start write.

Verification
REQ-037 Basic transfer: tick every 4 clks, write 8'hC1 to FF46 -> src_addr C100..C19F in order; 160 oam_we with oam_addr 0..159 and data matching source; dma_active low after the last write; first read on the 2nd tick.
REQ-038 Echo fold: write 8'hE2 -> src_addr starts at 16'hC200.
REQ-039 Restart: write 8'hC0, then 8'hD0 after 10 bytes -> bytes 0..9 written from C0xx (byte 9 still written if restart lands in WRITE); then one DELAY tick; then idx restarts at 0 from D000.
REQ-040 Reset mid-transfer: reset low at byte 50 -> all outputs 0 immediately; no oam_we after release; reg_rdata=0.
REQ-041 Stalled ticks: tick held low for 20 clks during READ -> no src_rd_req and dma_active held at 1; resumes at the same idx.
REQ-042 Non-matching write: write 8'hC0 to FF47 -> no state change and dma_active stays 0.
